// File: rtl/fir_rf_writeback_pkg.sv
// Shared types and default widths for the FIR offload interface blocks.
package fir_pkg;

  localparam int FIR_ADDR_W = 5;
  localparam int FIR_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DRAIN
  } fir_wb_state_t;

endpackage

// File: rtl/fir_rf_writeback_if.sv
// Bundle of CPU request, FIR controller handshake/write stream and merged RF write port.
interface fir_rf_writeback_if #(
  parameter int ADDR_W = fir_pkg::FIR_ADDR_W,
  parameter int DATA_W = fir_pkg::FIR_DATA_W
);
  logic              cpu_fir_go;
  logic              fir_start;
  logic              fir_done;
  logic              fir_rf_we;
  logic [ADDR_W-1:0] fir_rf_waddr;
  logic [DATA_W-1:0] fir_rf_wdata;
  logic              cpu_wb_we;
  logic [ADDR_W-1:0] cpu_wb_waddr;
  logic [DATA_W-1:0] cpu_wb_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fir_busy;
  logic              fir_complete;
  logic              fir_ovf;

  // Driven by the CPU/FIR-controller side.
  modport master (
    output cpu_fir_go, fir_done, fir_rf_we, fir_rf_waddr, fir_rf_wdata,
           cpu_wb_we, cpu_wb_waddr, cpu_wb_wdata,
    input  fir_start, rf_we, rf_waddr, rf_wdata, fir_busy, fir_complete, fir_ovf
  );

  // The writeback block itself.
  modport slave (
    input  cpu_fir_go, fir_done, fir_rf_we, fir_rf_waddr, fir_rf_wdata,
           cpu_wb_we, cpu_wb_waddr, cpu_wb_wdata,
    output fir_start, rf_we, rf_waddr, rf_wdata, fir_busy, fir_complete, fir_ovf
  );

endinterface

// File: rtl/fir_rf_writeback_fifo.sv
// Small FIFO buffering FIR register writes; pointers carry an extra wrap bit.
module fir_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign dout     = mem_q[rd_ptr_q[PW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; emptiness comes from the pointers, so stale data is never read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_rf_writeback.sv
// Processor-side FIR offload end: start/done handshake FSM and merge of buffered FIR
// register writes into the single RF write port, with CPU writeback taking priority.
module fir_rf_writeback
  import fir_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = FIR_ADDR_W,
  parameter int DATA_W = FIR_DATA_W
) (
  input logic                 clock,
  input logic                 reset,
  fir_rf_writeback_if.slave   bus
);

  localparam int WIDTH = ADDR_W + DATA_W;

  fir_wb_state_t     state_q, state_d;
  logic              start_q, start_d;
  logic              complete_q, complete_d;
  logic              ovf_q, ovf_d;

  logic              push_v;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_dout;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              overflow;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // x0 is hard-wired, so writes to it never occupy a FIFO slot.
  assign push_v   = bus.fir_rf_we && (bus.fir_rf_waddr != '0);
  assign pop_req  = !bus.cpu_wb_we && !fifo_empty;
  assign overflow = push_v && fifo_full && !pop_req;

  fir_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_v),
    .pop   (pop_req),
    .din   ({bus.fir_rf_waddr, bus.fir_rf_wdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_addr, head_data} = fifo_dout;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    complete_d = 1'b0;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: if (bus.cpu_fir_go) begin
        state_d = START;
        ovf_d   = 1'b0;
      end
      START: if (bus.fir_done) state_d = DRAIN;
      DRAIN: if (fifo_empty && !push_v) begin
        state_d    = IDLE;
        complete_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A fresh overflow outranks the clear from a simultaneous accepted request.
    if (overflow) ovf_d = 1'b1;
    start_d = (state_d == START);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      complete_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      complete_q <= complete_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (bus.cpu_wb_we) begin
      rf_we    = 1'b1;
      rf_waddr = bus.cpu_wb_waddr;
      rf_wdata = bus.cpu_wb_wdata;
    end else if (!fifo_empty) begin
      rf_we    = 1'b1;
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end
  end

  assign bus.rf_we        = rf_we;
  assign bus.rf_waddr     = rf_waddr;
  assign bus.rf_wdata     = rf_wdata;
  assign bus.fir_start    = start_q;
  assign bus.fir_busy     = (state_q != IDLE);
  assign bus.fir_complete = complete_q;
  assign bus.fir_ovf      = ovf_q;

endmodule

// File: tb/tb_fir_rf_writeback.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor compares.
module tb_fir_rf_writeback;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              start;
    logic              busy;
    logic              complete;
    logic              ovf;
  } exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  fir_rf_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fir_rf_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: run phase 0=idle, 1=waiting for done, 2=draining.
  int   phase = 0;
  bit   cmp_m = 0;
  bit   ovf_m = 0;
  wr_t  pend_q[$];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    cmp_m = 0;
    ovf_m = 0;
    pend_q.delete();
    exp_q.delete();
  endtask

  // Called at posedge+1: drive one cycle of inputs, queue the expected outputs, advance model.
  task automatic step(input bit go, input bit done, input bit fwe, input logic [ADDR_W-1:0] fa,
                      input logic [DATA_W-1:0] fd, input bit cwe, input logic [ADDR_W-1:0] ca,
                      input logic [DATA_W-1:0] cd);
    exp_t e;
    bit   popped, pushv, was_empty;
    bus.cpu_fir_go   = go;
    bus.fir_done     = done;
    bus.fir_rf_we    = fwe;
    bus.fir_rf_waddr = fa;
    bus.fir_rf_wdata = fd;
    bus.cpu_wb_we    = cwe;
    bus.cpu_wb_waddr = ca;
    bus.cpu_wb_wdata = cd;

    e = '0;
    e.start    = (phase == 1);
    e.busy     = (phase != 0);
    e.complete = cmp_m;
    e.ovf      = ovf_m;
    if (cwe) begin
      e.we = 1; e.addr = ca; e.data = cd;
    end else if (pend_q.size() > 0) begin
      e.we = 1; e.addr = pend_q[0].addr; e.data = pend_q[0].data;
    end
    exp_q.push_back(e);

    was_empty = (pend_q.size() == 0);
    popped    = !cwe && !was_empty;
    pushv     = fwe && (fa != 0);
    if (popped) void'(pend_q.pop_front());
    cmp_m = (phase == 2) && was_empty && !pushv;
    if (phase == 0 && go) ovf_m = 0;
    if (pushv) begin
      if (pend_q.size() < DEPTH) pend_q.push_back('{addr: fa, data: fd});
      else ovf_m = 1;
    end
    case (phase)
      0: if (go) phase = 1;
      1: if (done) phase = 2;
      default: if (was_empty && !pushv) phase = 0;
    endcase

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_we"},    64'(bus.rf_we),        0);
    check({tag, "_rf_waddr"}, 64'(bus.rf_waddr),     0);
    check({tag, "_rf_wdata"}, 64'(bus.rf_wdata),     0);
    check({tag, "_start"},    64'(bus.fir_start),    0);
    check({tag, "_busy"},     64'(bus.fir_busy),     0);
    check({tag, "_complete"}, 64'(bus.fir_complete), 0);
    check({tag, "_ovf"},      64'(bus.fir_ovf),      0);
  endtask

  // Monitor: one expected record per cycle, compared away from the active edge.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fir_start, bus.fir_busy,
             bus.fir_complete, bus.fir_ovf};
        check($sformatf("cycle%0d", cyc), 64'(a), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_fir_go = 0; bus.fir_done = 0; bus.fir_rf_we = 0; bus.fir_rf_waddr = 0;
    bus.fir_rf_wdata = 0; bus.cpu_wb_we = 0; bus.cpu_wb_waddr = 0; bus.cpu_wb_wdata = 0;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    #1 check_all_zero("reset");
    @(posedge clk);
    #1;

    // Handshake: done ten cycles after the request, FIFO empty.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(9);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Single FIR write.
    step(0, 0, 1, 5'd5, 32'h0000_1234, 0, 0, 0);
    idle(2);

    // CPU priority over queued FIR writes.
    step(0, 0, 1, 5'd10, 32'hA, 1, 5'd1, 32'h1111);
    step(0, 0, 1, 5'd11, 32'hB, 1, 5'd1, 32'h2222);
    step(0, 0, 1, 5'd12, 32'hC, 1, 5'd1, 32'h3333);
    idle(4);

    // Overflow: five pushes while the port is held by the CPU, then a request clears it.
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 5'(20 + i), 32'(32'hF00 + i), 1, 5'd2, 32'(i));
    idle(6);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // x0 writes are discarded.
    step(0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] fa;
      fa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           fa, $urandom, $urandom_range(0, 2) == 0, 5'($urandom), $urandom);
    end
    idle(10);

    // Reset while draining with two entries queued.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5'd7, 32'h77, 1, 5'd3, 32'h33);
    step(0, 0, 1, 5'd8, 32'h88, 1, 5'd3, 32'h44);
    bus.cpu_fir_go = 0; bus.fir_done = 0; bus.fir_rf_we = 0; bus.fir_rf_waddr = 0;
    bus.fir_rf_wdata = 0; bus.cpu_wb_we = 0; bus.cpu_wb_waddr = 0; bus.cpu_wb_wdata = 0;
    #1 rst = 1;
    model_reset();
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
    idle(6);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
